// File: rtl/key_event_decoder_if.sv
// Key event bundle: the debounced key level going into the decoder and the
// single-cycle event pulses plus held level coming out of it.
// master = decoder side, slave = consumer side (control FSMs / stimulus).
interface key_event_decoder_if;
  logic key_db;
  logic press_pulse;
  logic release_pulse;
  logic click_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic key_held;

  modport master (
    input  key_db,
    output press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, key_held
  );

  modport slave (
    output key_db,
    input  press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, key_held
  );
endinterface

// File: rtl/key_event_decoder.sv
// key_event_decoder: turns the debounced key level into registered one-cycle
// events (press, release, click, long press, auto-repeat). All timing is in
// clk_100kHz ticks.
// Optional feature macro: KEY_REPEAT_EN (auto-repeat while held after a long
// press). Without it repeat_pulse is constant 0 and the hold counter rests at 0
// in LONG.
module key_event_decoder #(
  parameter int LONG_TICKS   = 100000,
  parameter int REPEAT_TICKS = 20000,
  parameter int CNT_W        = 17
) (
  input  logic             clk_100kHz,
  input  logic             rst,
  key_event_decoder_if.master ev
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);

  // The counter must reach both thresholds without wrapping.
  localparam bit PARAMS_OK = ((64'd1 << CNT_W) > 64'(LONG_TICKS)) &&
                             ((64'd1 << CNT_W) > 64'(REPEAT_TICKS)) &&
                             (LONG_TICKS > 0) && (REPEAT_TICKS > 0);
  if (!PARAMS_OK) begin : g_bad_params
    $error("key_event_decoder: CNT_W too small or tick parameter not positive");
  end

`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             key_q;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             click_q, click_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             rise, fall;

  assign rise = ev.key_db & ~key_q;
  assign fall = ~ev.key_db & key_q;

  // State, hold counter, key history and registered event outputs
  always_ff @(posedge clk_100kHz) begin
    if (rst) begin
      state_q    <= IDLE;
      hold_cnt_q <= '0;
      key_q      <= 1'b0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      click_q    <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      key_q      <= ev.key_db;
      press_q    <= press_d;
      release_q  <= release_d;
      click_q    <= click_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
    end
  end

  // Next-state and event decode; a fall always wins over a same-edge threshold
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    click_d    = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;

    case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        if (rise) begin
          press_d = 1'b1;
          state_d = PRESSED;
        end
      end

      PRESSED: begin
        if (fall) begin
          release_d  = 1'b1;
          click_d    = 1'b1;
          hold_cnt_d = '0;
          state_d    = IDLE;
        end else if (ev.key_db && (hold_cnt_q == LONG_LAST)) begin
          long_d     = 1'b1;
          hold_cnt_d = '0;
          state_d    = LONG;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      LONG: begin
        if (fall) begin
          release_d  = 1'b1;
          hold_cnt_d = '0;
          state_d    = IDLE;
        end else begin
`ifdef KEY_REPEAT_EN
          if (ev.key_db && (hold_cnt_q == REPEAT_LAST)) begin
            repeat_d   = 1'b1;
            hold_cnt_d = '0;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
`else
          hold_cnt_d = '0;
`endif
        end
      end

      default: begin
        hold_cnt_d = '0;
        state_d    = IDLE;
      end
    endcase
  end

  assign ev.press_pulse   = press_q;
  assign ev.release_pulse = release_q;
  assign ev.click_pulse   = click_q;
  assign ev.long_pulse    = long_q;
  assign ev.repeat_pulse  = repeat_q;
  assign ev.key_held      = (state_q != IDLE);

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder with LONG_TICKS=10, REPEAT_TICKS=4, CNT_W=5.
// Directed sequences followed by random key/reset activity, every cycle
// compared against a timestamp-based reference model.
module tb_key_event_decoder;
  localparam int LONG_T = 10;
  localparam int REP_T  = 4;
`ifdef KEY_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk_100kHz = 1'b0;
  logic rst = 1'b1;
  always #5 clk_100kHz = ~clk_100kHz;

  key_event_decoder_if ev();

  key_event_decoder #(
    .LONG_TICKS  (LONG_T),
    .REPEAT_TICKS(REP_T),
    .CNT_W       (5)
  ) dut (
    .clk_100kHz(clk_100kHz),
    .rst       (rst),
    .ev        (ev)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;

  // Reference model: key "held" flag plus timestamps of the press and long events.
  bit m_prev, m_held, m_long_done;
  int m_t_press, m_t_long;
  bit e_press, e_release, e_click, e_long, e_repeat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, t);
    end
  endtask

  task automatic model_step(input bit r, input bit k);
    e_press = 0; e_release = 0; e_click = 0; e_long = 0; e_repeat = 0;
    if (r) begin
      m_prev = 0; m_held = 0; m_long_done = 0;
    end else begin
      if (!m_held) begin
        if (k && !m_prev) begin
          e_press = 1; m_held = 1; m_long_done = 0; m_t_press = t;
        end
      end else if (!k && m_prev) begin
        e_release = 1; e_click = !m_long_done; m_held = 0;
      end else if (!m_long_done) begin
        if (t - m_t_press == LONG_T) begin
          e_long = 1; m_long_done = 1; m_t_long = t;
        end
      end else if (REP_EN && (t > m_t_long) && ((t - m_t_long) % REP_T == 0)) begin
        e_repeat = 1;
      end
      m_prev = k;
    end
  endtask

  task automatic tick(input bit k, input bit r);
    rst = r;
    ev.key_db = k;
    @(posedge clk_100kHz);
    t++;
    model_step(r, k);
    #1;
    check("press",   ev.press_pulse,   e_press);
    check("release", ev.release_pulse, e_release);
    check("click",   ev.click_pulse,   e_click);
    check("long",    ev.long_pulse,    e_long);
    check("repeat",  ev.repeat_pulse,  e_repeat);
    check("held",    ev.key_held,      m_held);
    check("press_rel_excl", ev.press_pulse & ev.release_pulse, 1'b0);
    check("click_long_excl", ev.click_pulse & ev.long_pulse, 1'b0);
  endtask

  task automatic hold(input bit k, input int n, input bit r);
    for (int i = 0; i < n; i++) tick(k, r);
  endtask

  initial begin
    ev.key_db = 1'b0;
    m_prev = 0; m_held = 0; m_long_done = 0; m_t_press = 0; m_t_long = 0;
    @(negedge clk_100kHz);
    // 1: reset with key held, then the held key shows up as a fresh press
    hold(1, 3, 1);
    hold(1, 1, 0);
    hold(1, 2, 0);
    hold(0, 3, 0);
    // 2: short click
    hold(1, 5, 0);
    hold(0, 3, 0);
    // 3: long press then release
    hold(1, 20, 0);
    hold(0, 3, 0);
    // 4: long hold for auto-repeat
    hold(1, 30, 0);
    hold(0, 3, 0);
    // 5: fall on the long threshold edge, and either side of it
    hold(1, 10, 0);
    hold(0, 3, 0);
    hold(1, 9, 0);
    hold(0, 2, 0);
    hold(1, 11, 0);
    hold(0, 2, 0);
    // fall on a repeat threshold edge
    hold(1, 14, 0);
    hold(0, 2, 0);
    // 6: reset during LONG with key still held
    hold(1, 15, 0);
    hold(1, 2, 1);
    hold(1, 3, 0);
    hold(0, 3, 0);
    // random key activity with occasional resets
    for (int s = 0; s < 200; s++) begin
      int len;
      bit rr;
      len = $urandom_range(1, 30);
      rr  = ($urandom_range(0, 19) == 0);
      hold(s[0], rr ? 2 : len, rr);
    end
    hold(0, 3, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
